// File: rtl/cpu_defs.sv
// Shared execute-stage definitions: divider FSM encoding and iteration count.
package cpu_defs;

   localparam int unsigned DIV_WIDTH  = 32;
   localparam int unsigned DIV_CYCLES = DIV_WIDTH;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'd0,
      DIV_DIVZERO = 2'd1,
      DIV_CALC    = 2'd2,
      DIV_DONE    = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_if.sv
// Pipeline-side handshake between the E stage / hazard unit and the divider.
interface div_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 start;
   logic                 signed_div;
   logic                 annul;
   logic [WIDTH-1:0]     opa;
   logic [WIDTH-1:0]     opb;
   logic [2*WIDTH-1:0]   result;
   logic                 ready;
   logic                 stall_div;

   modport master (
      output start, signed_div, annul, opa, opb,
      input  result, ready, stall_div
   );

   modport slave (
      input  start, signed_div, annul, opa, opb,
      output result, ready, stall_div
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             din,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem, din};
      diff    = shifted - {1'b0, divisor};
      // No borrow out of the (WIDTH+1)-bit subtract means the divisor fits.
      q        = ~diff[WIDTH];
      rem_next = q ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; stalls F/D/E until the result is ready.
module div_unit
   import cpu_defs::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input logic  clk,
   input logic  resetn,
   div_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
   logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;
   logic               q_bit, sign_q, sign_r, go;
   logic [2*WIDTH-1:0] result_q;

   assign go = bus.start & ~bus.annul;

   // quo_q doubles as the dividend shift register; its MSB feeds the step.
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .din      (quo_q[WIDTH-1]),
      .divisor  (dvsr_q),
      .rem_next (rem_nx),
      .q        (q_bit)
   );

   always_comb begin
      quo_nx  = {quo_q[WIDTH-2:0], q_bit};
      rem_fix = sign_r ? -rem_nx : rem_nx;
      quo_fix = sign_q ? -quo_nx : quo_nx;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_IDLE:    if (go) state_d = (bus.opb == '0) ? DIV_DIVZERO : DIV_CALC;
         DIV_DIVZERO: state_d = DIV_DONE;
         DIV_CALC:    if (cnt_q == LAST) state_d = DIV_DONE;
         DIV_DONE:    state_d = DIV_IDLE;
         default:     state_d = DIV_IDLE;
      endcase
      if (bus.annul) state_d = DIV_IDLE;
   end

   always_comb begin
      bus.stall_div = go & (state_q != DIV_DONE);
      bus.ready     = (state_q == DIV_DONE) & ~bus.annul;
      bus.result    = result_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= DIV_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            DIV_IDLE: if (go) begin
               rem_q  <= '0;
               cnt_q  <= '0;
               quo_q  <= (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
               dvsr_q <= (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
               sign_q <= bus.signed_div & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
               sign_r <= bus.signed_div & bus.opa[WIDTH-1];
            end
            DIV_CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 1'b1;
               // Result is registered on the way into DONE so it is stable for the ready pulse.
               if (cnt_q == LAST && !bus.annul) result_q <= {rem_fix, quo_fix};
            end
            DIV_DIVZERO: if (!bus.annul) result_q <= '0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor checks each ready pulse.
module tb_div_unit;
   logic clk = 1'b0;
   logic resetn;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [63:0] sb_q[$];
   time  last_ready_t;

   always #5 clk = ~clk;

   div_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero, remainder follows dividend.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      if (b == 0) return 64'd0;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   always @(negedge clk) begin
      if (resetn && bus.ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 with result %h, expected no pulse",
                     bus.result);
         end else begin
            check("result", bus.result, sb_q.pop_front());
         end
      end
   end

   // Issues one divide, leaves start high; checks stall length and ready latency.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] exp, input bit scramble);
      int  k, stalls, lat_exp;
      bit  seen;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.opa = a; bus.opb = b; bus.signed_div = sg;
      sb_q.push_back(exp);
      lat_exp = (b == 0) ? 2 : 33;
      stalls = 0; seen = 1'b0; k = 0;
      while (k < 100 && !seen) begin
         if (k > 0) begin
            @(posedge clk); #1;
            if (scramble) begin
               bus.opa = $urandom; bus.opb = $urandom; bus.signed_div = 1'($urandom);
            end
         end
         @(negedge clk);
         if (bus.ready) begin
            seen = 1'b1;
            check("latency", 64'(k), 64'(lat_exp));
            last_ready_t = $time;
         end else if (bus.stall_div) begin
            stalls++;
         end
         k++;
      end
      if (!seen) check("ready_timeout", 64'd0, 64'd1);
      check("stall_cycles", 64'(stalls), 64'(lat_exp));
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b;
      logic        sg;
      time         t1;
      resetn = 1'b0;
      bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
      bus.opa = '0; bus.opb = '0;
      #23;
      check("reset_result", bus.result, 64'd0);
      check("reset_ready", 64'(bus.ready), 64'd0);
      @(negedge clk); resetn = 1'b1;

      do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);
      go_idle();
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
      go_idle();
      do_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 1'b0);
      go_idle();
      do_div(32'd1234, 32'd0, 1'b0, 64'd0, 1'b0);
      go_idle();
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1'b0);
      go_idle();
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 1'b0);
      go_idle();

      // Annul at T+10: stall drops that cycle, no ready, fresh start at T+12.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.opa = 32'd999; bus.opb = 32'd10; bus.signed_div = 1'b0;
      repeat (10) @(posedge clk);
      #1 bus.annul = 1'b1;
      @(negedge clk);
      check("annul_stall", 64'(bus.stall_div), 64'd0);
      @(posedge clk); #1;
      bus.annul = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      check("annul_no_stall_idle", 64'(bus.stall_div), 64'd0);
      do_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 1'b0);
      go_idle();

      // Asynchronous reset mid-CALC clears outputs without a clock edge.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.opa = 32'd50; bus.opb = 32'd5; bus.signed_div = 1'b0;
      repeat (10) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("async_reset_result", bus.result, 64'd0);
      check("async_reset_ready", 64'(bus.ready), 64'd0);
      bus.start = 1'b0;
      @(negedge clk); resetn = 1'b1;

      // Back-to-back with start held, operands scrambled during CALC.
      do_div(32'd77777, 32'd123, 1'b0, ref_div(32'd77777, 32'd123, 1'b0), 1'b1);
      t1 = last_ready_t;
      do_div(32'hFFFF_0000, 32'd9, 1'b1, ref_div(32'hFFFF_0000, 32'd9, 1'b1), 1'b1);
      check("b2b_spacing", 64'(last_ready_t - t1), 64'd340);
      go_idle();

      for (int i = 0; i < 16; i++) begin
         a  = $urandom;
         b  = (i % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i % 5 == 0) b = -b;
         sg = 1'($urandom);
         do_div(a, b, sg, ref_div(a, b, sg), 1'($urandom));
         if (i % 3 == 0) go_idle();
      end
      go_idle();

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
